// File: rtl/reset_sequencer_if.sv
// Reset-sequencer output bundle: warm-reset request in, per-channel resets and status out.
// sw_rst_req is a level request sampled on every clk edge; there is no acknowledge.
interface reset_sequencer_if #(
  parameter int N_CH = 3
);
  logic            sw_rst_req;
  logic [N_CH-1:0] rst;
  logic            rst_done;
  logic [1:0]      seq_state;

  modport master (
    input  sw_rst_req,
    output rst,
    output rst_done,
    output seq_state
  );

  modport slave (
    output sw_rst_req,
    input  rst,
    input  rst_done,
    input  seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Board reset bridge plus ordered release of N_CH reset channels, with software warm reset.
// Async assert / sync release; every output comes straight from a flop.
module reset_sequencer #(
  parameter int N_SYNC      = 2,
  parameter int N_DEBOUNCE  = 4,
  parameter int N_CH        = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               arst,
  reset_sequencer_if.master  bus
);

  localparam int DEB_W  = $clog2(N_DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = $clog2(N_CH + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(N_DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    HOLD  = 2'd1,
    STAGE = 2'd2,
    RUN   = 2'd3
  } seq_state_t;

  (* ASYNC_REG = "TRUE" *) logic [N_SYNC-1:0] sync_q;
  logic              arst_sync;
  seq_state_t        state_q;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  ch_idx;
  logic [N_CH-1:0]   rst_q;
  logic              done_q;

  assign arst_sync     = sync_q[N_SYNC-1];
  assign bus.rst       = rst_q;
  assign bus.rst_done  = done_q;
  assign bus.seq_state = state_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync_q   <= '0;
      state_q  <= SYNC;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      ch_idx   <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], 1'b1};
      // A warm request outranks any counter terminal reached on the same edge.
      if (state_q != SYNC && bus.sw_rst_req) begin
        state_q  <= HOLD;
        hold_cnt <= '0;
        gap_cnt  <= '0;
        ch_idx   <= '0;
        rst_q    <= '1;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          SYNC: begin
            if (!arst_sync) begin
              deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              state_q  <= HOLD;
              hold_cnt <= '0;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              // Channels release low index first: shifting a zero in from bit 0.
              rst_q <= rst_q << 1;
              if (N_CH == 1) begin
                state_q <= RUN;
                done_q  <= 1'b1;
              end else begin
                state_q <= STAGE;
                ch_idx  <= IDX_W'(1);
                gap_cnt <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          STAGE: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              rst_q   <= rst_q << 1;
              if (ch_idx == IDX_LAST) begin
                state_q <= RUN;
                done_q  <= 1'b1;
              end else begin
                ch_idx <= ch_idx + IDX_W'(1);
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          RUN: begin
            state_q <= RUN;
          end
          default: begin
            state_q <= SYNC;
          end
        endcase
      end
    end
  end

endmodule
